// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker
// Boot-time Avalon-MM read master. On start it reads word 0 (system ID) and
// then word 1 (build timestamp), compares both against the expected values,
// and latches the captured words plus status flags for downstream consumers.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start after reset
// S_ID_REQ  | read strobe for word 0 pending (held through waitrequest)
// S_ID_WAIT | word 0 read accepted, waiting for readdatavalid
// S_TS_REQ  | read strobe for word 1 pending (held through waitrequest)
// S_TS_WAIT | word 1 read accepted, waiting for readdatavalid
// S_FIN     | check complete, results held, done high, start re-arms
//
// A timed-out attempt drops avm_read and re-enters the REQ state with the
// strobe low for one cycle, so each retry is a distinct read transaction.
// The attempt timer only runs once the strobe is actually on the bus.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1429586131,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID_REQ,
    S_ID_WAIT,
    S_TS_REQ,
    S_TS_WAIT,
    S_FIN
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] to_q, to_d;
  logic [3:0]  retry_q, retry_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        to_err_q, to_err_d;
  logic [31:0] id_val_q, id_val_d;
  logic [31:0] ts_val_q, ts_val_d;

  logic in_req;
  logic in_wait;
  logic on_ts_word;
  logic counting;
  logic accept;
  logic capture;
  logic expire;

  assign in_req     = (state_q == S_ID_REQ)  || (state_q == S_TS_REQ);
  assign in_wait    = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
  assign on_ts_word = (state_q == S_TS_REQ)  || (state_q == S_TS_WAIT);
  assign counting   = in_wait || (in_req && read_q);
  assign accept     = in_req && read_q && !avm_waitrequest;
  assign capture    = in_wait && avm_readdatavalid;
  // Capture beats expiry in the same cycle, so no retry is spent on it.
  assign expire     = counting && (to_q == TO_LAST) && !capture;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    to_d     = to_q;
    retry_d  = retry_q;
    read_d   = read_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    id_ok_d  = id_ok_q;
    ts_ok_d  = ts_ok_q;
    to_err_d = to_err_q;
    id_val_d = id_val_q;
    ts_val_d = ts_val_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d  = S_ID_REQ;
          read_d   = 1'b1;
          addr_d   = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          id_ok_d  = 1'b0;
          ts_ok_d  = 1'b0;
          to_err_d = 1'b0;
          retry_d  = '0;
          to_d     = '0;
        end
      end

      S_ID_REQ, S_TS_REQ: begin
        // readdatavalid here belongs to an abandoned attempt and is ignored.
        if (!read_q) begin
          read_d = 1'b1;
          to_d   = '0;
        end else if (accept) begin
          read_d  = 1'b0;
          state_d = on_ts_word ? S_TS_WAIT : S_ID_WAIT;
          to_d    = to_q + 16'd1;
        end else begin
          to_d = to_q + 16'd1;
        end
      end

      S_ID_WAIT: begin
        if (capture) begin
          id_val_d = avm_readdata;
          id_ok_d  = (avm_readdata == EXPECTED_ID);
          retry_d  = '0;
          to_d     = '0;
          state_d  = S_TS_REQ;
          read_d   = 1'b1;
          addr_d   = 1'b1;
        end else begin
          to_d = to_q + 16'd1;
        end
      end

      S_TS_WAIT: begin
        if (capture) begin
          ts_val_d = avm_readdata;
          ts_ok_d  = (avm_readdata == EXPECTED_TIMESTAMP);
          retry_d  = '0;
          to_d     = '0;
          state_d  = S_FIN;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          to_d = to_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Attempt timer ran out: drop the strobe, then retry or give up.
    if (expire) begin
      read_d = 1'b0;
      to_d   = '0;
      if (retry_q < RETRY_LIMIT) begin
        retry_d = retry_q + 4'd1;
        state_d = on_ts_word ? S_TS_REQ : S_ID_REQ;
      end else begin
        to_err_d = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = S_FIN;
      end
    end
  end

  // State and output registers; reset clears everything including the strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      to_q     <= '0;
      retry_q  <= '0;
      read_q   <= 1'b0;
      addr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      to_err_q <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
    end else begin
      state_q  <= state_d;
      to_q     <= to_d;
      retry_q  <= retry_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      to_err_q <= to_err_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = to_err_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;

endmodule
